ff_m_wr_sched: RTL
==================

FF_M_WR_SCHED -- requirements
Module: ff_m_wr_sched

Interface
REQ-001 Parameter WIDTH, default 4, data width of one write word.
REQ-002 Parameter BITADDR, default 5, address width.
REQ-003 Parameter FIFODEPTH, default 4, request queue depth; power of 2 and at least 2.
REQ-004 The write-port count SHALL be fixed at 2; this is not a parameter.
REQ-005 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1, synchronous, active-high reset.
REQ-007 Port in_vld, input, 1, a client write request is valid.
REQ-008 Port in_rdy, output, 1, the queue can accept a request.
REQ-009 Port in_adr, input, BITADDR, request address.
REQ-010 Port in_din, input, WIDTH, request data.
REQ-011 Port in_bw, input, WIDTH, request bit-write enables.
REQ-012 Port hold, input, 1, freezes issue to the flop array.
REQ-013 Port write, output, 2, per-port write strobe to the flop array.
REQ-014 Port wr_adr, output, 2*BITADDR, per-port address; port p occupies slice [p*BITADDR +: BITADDR].
REQ-015 Port din, output, 2*WIDTH, per-port data; port p occupies slice [p*WIDTH +: WIDTH].
REQ-016 Port bw, output, 2*WIDTH, per-port bit enables, sliced the same way as din.
REQ-017 Port count, output, $clog2(FIFODEPTH)+1, number of queued entries.

Function
REQ-018 A request SHALL be accepted only on a cycle where in_vld=1 and in_rdy=1; it is then pushed into the queue tail at that edge.
REQ-019 in_rdy SHALL be (count < FIFODEPTH) and not rst; it SHALL NOT depend on same-cycle pops.
REQ-020 A push attempted while the queue is full (in_vld=1, in_rdy=0) SHALL be ignored, with no state change.
REQ-021 Each edge with hold=0, the block SHALL examine up to two head entries: E0 (oldest) and E1 (next).
REQ-022 Count = 0: write SHALL be set to 2'b00.
REQ-023 Count = 1: E0 SHALL issue on port 0, write=2'b01, one pop.
REQ-024 Count >= 2, adr(E0) != adr(E1): E0 SHALL issue on port 0, E1 on port 1, write=2'b11, two pops.
REQ-025 Count >= 2, adr(E0) == adr(E1): the two entries SHALL merge onto port 0, write=2'b01, two pops, with:
- bw = bw0 | bw1
- din = (din1 & bw1) | (din0 & bw0 & ~bw1); the younger entry wins on overlapping bits.
REQ-026 Port 0 SHALL always carry the older entry; issue order SHALL equal acceptance order.
REQ-027 write, wr_adr, din and bw SHALL be registered.
REQ-028 On any idle port, wr_adr, din and bw SHALL be driven to 0.
REQ-029 Latency: a request accepted at edge N into an empty queue SHALL appear on the outputs after edge N+1.
REQ-030 The issue decision at an edge SHALL use only entries present before that edge; an entry pushed at the same edge is not a candidate.
REQ-031 hold=1: no pops, write SHALL be 2'b00, pushes continue normally.
REQ-032 Simultaneous push and pop: the count update SHALL be count + push - pops.
REQ-033 A full queue with a same-edge pop SHALL still reject the push, per REQ-019.
REQ-034 Read and write pointers SHALL wrap modulo FIFODEPTH.
REQ-035 Only the two head entries are compared; no deeper coalescing SHALL occur.

Reset
REQ-036 While rst=1 at an edge, the block SHALL clear: pointers, count=0, write=0, wr_adr=0, din=0, bw=0.
REQ-037 in_rdy SHALL be 0 while rst is high.
REQ-038 A reset mid-operation SHALL discard all queued entries; no write SHALL issue in the cycle after reset.
REQ-039 Queue storage contents need no reset.

Verification
REQ-040 Single request, empty queue, hold=0: push adr=3, din=4'hA, bw=4'hF -> one cycle later write=01, wr_adr[0]=3, din[0]=A, bw[0]=F; following cycle write=00.
REQ-041 Different addresses: with hold=1, push (adr=1, din=4'h5, bw=4'hF) then (adr=2, din=4'h6, bw=4'hF); release hold -> write=11, port0 = adr 1 / din 5, port1 = adr 2 / din 6; count=0.
REQ-042 Same address merge: with hold=1, push (adr=7, din=4'hC, bw=4'hC) then (adr=7, din=4'h3, bw=4'h6); release -> write=01, wr_adr[0]=7, bw[0]=4'hE, din[0]=4'hA.
REQ-043 Full queue: with hold=1, push 5 requests -> 5th rejected, in_rdy=0, count=4; release hold -> 2 cycles of write=11 in acceptance order, then count=0.
REQ-044 Reset mid-operation: 3 queued entries, hold=1, assert rst for one edge -> count=0, write=00 on the next cycle, in_rdy=1 after rst drops.
REQ-045 Streaming: in_vld held at 1 for 20 cycles with distinct addresses, hold=0 -> no rejections, every request written exactly once and in order.

Source files
------------

// File: rtl/ff_m_wr_sched.sv
// Two-port write scheduler: queues client writes and issues up to two per cycle
// to a flop array, merging the two head entries when they target the same address.
module ff_m_wr_sched #(
    parameter int WIDTH     = 4,
    parameter int BITADDR   = 5,
    parameter int FIFODEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [BITADDR-1:0]           in_adr,
    input  logic [WIDTH-1:0]             in_din,
    input  logic [WIDTH-1:0]             in_bw,
    input  logic                         hold,
    output logic [1:0]                   write,
    output logic [2*BITADDR-1:0]         wr_adr,
    output logic [2*WIDTH-1:0]           din,
    output logic [2*WIDTH-1:0]           bw,
    output logic [$clog2(FIFODEPTH):0]   count
);

    localparam int PW = $clog2(FIFODEPTH);
    localparam int CW = PW + 1;

    logic [BITADDR-1:0] adr_mem_q [FIFODEPTH];
    logic [WIDTH-1:0]   din_mem_q [FIFODEPTH];
    logic [WIDTH-1:0]   bw_mem_q  [FIFODEPTH];

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           write_q, write_d;
    logic [2*BITADDR-1:0] wr_adr_q, wr_adr_d;
    logic [2*WIDTH-1:0]   din_q, din_d;
    logic [2*WIDTH-1:0]   bw_q, bw_d;

    logic                 push;
    logic [1:0]           pops;
    logic [PW-1:0]        e1_idx;
    logic [BITADDR-1:0]   adr0, adr1;
    logic [WIDTH-1:0]     din0, din1, bw0, bw1;

    // Ready looks only at the registered count, never at this cycle's pops.
    assign in_rdy = (count_q < CW'(FIFODEPTH)) && !rst;
    assign push   = in_vld && in_rdy;

    assign e1_idx = rd_ptr_q + PW'(1);
    assign adr0   = adr_mem_q[rd_ptr_q];
    assign din0   = din_mem_q[rd_ptr_q];
    assign bw0    = bw_mem_q[rd_ptr_q];
    assign adr1   = adr_mem_q[e1_idx];
    assign din1   = din_mem_q[e1_idx];
    assign bw1    = bw_mem_q[e1_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem_q[wr_ptr_q] <= in_adr;
            din_mem_q[wr_ptr_q] <= in_din;
            bw_mem_q[wr_ptr_q]  <= in_bw;
        end
    end

    always_comb begin
        write_d  = 2'b00;
        wr_adr_d = '0;
        din_d    = '0;
        bw_d     = '0;
        pops     = 2'd0;
        if (!hold) begin
            if (count_q == CW'(1)) begin
                write_d                  = 2'b01;
                wr_adr_d[0 +: BITADDR]   = adr0;
                din_d[0 +: WIDTH]        = din0;
                bw_d[0 +: WIDTH]         = bw0;
                pops                     = 2'd1;
            end else if (count_q >= CW'(2)) begin
                pops = 2'd2;
                if (adr0 == adr1) begin
                    // Younger entry wins on overlapping enabled bits.
                    write_d                = 2'b01;
                    wr_adr_d[0 +: BITADDR] = adr0;
                    din_d[0 +: WIDTH]      = (din1 & bw1) | (din0 & bw0 & ~bw1);
                    bw_d[0 +: WIDTH]       = bw0 | bw1;
                end else begin
                    write_d                      = 2'b11;
                    wr_adr_d[0 +: BITADDR]       = adr0;
                    wr_adr_d[BITADDR +: BITADDR] = adr1;
                    din_d[0 +: WIDTH]            = din0;
                    din_d[WIDTH +: WIDTH]        = din1;
                    bw_d[0 +: WIDTH]             = bw0;
                    bw_d[WIDTH +: WIDTH]         = bw1;
                end
            end
        end
        rd_ptr_d = rd_ptr_q + PW'(pops);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pops);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            write_q  <= 2'b00;
            wr_adr_q <= '0;
            din_q    <= '0;
            bw_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            write_q  <= write_d;
            wr_adr_q <= wr_adr_d;
            din_q    <= din_d;
            bw_q     <= bw_d;
        end
    end

    assign write  = write_q;
    assign wr_adr = wr_adr_q;
    assign din    = din_q;
    assign bw     = bw_q;
    assign count  = count_q;

endmodule
